// File: rtl/dsp_mult_stage_if.sv
// Operand/product bundle for the DSP48A1 multiplier stage.
// The master drives operands; the slave (multiplier) returns the product and the B cascade.
interface dsp_mult_stage_if #(
    parameter int WIDTH_A = 18,
    parameter int WIDTH_B = 18
);
    logic                              in_valid;
    logic signed [WIDTH_A-1:0]         a_in;
    logic signed [WIDTH_B-1:0]         b_in;
    logic signed [WIDTH_A+WIDTH_B-1:0] m_out;
    logic signed [WIDTH_B-1:0]         bcout;
    logic                              out_valid;

    modport master (
        output in_valid, a_in, b_in,
        input  m_out, bcout, out_valid
    );

    modport slave (
        input  in_valid, a_in, b_in,
        output m_out, bcout, out_valid
    );
endinterface

// File: rtl/dsp_mult_stage.sv
// Pipelined signed multiplier stage: optional A1/B1 input registers and optional M register,
// with a valid tag carried alongside the operands so the post-adder knows when M is meaningful.
module dsp_mult_stage #(
    parameter int WIDTH_A = 18,
    parameter int WIDTH_B = 18,
    parameter int IREG    = 1,
    parameter int MREG    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             rst_i,
    input  logic             rst_m,
    dsp_mult_stage_if.slave  bus
);
    localparam int WP = WIDTH_A + WIDTH_B;

    logic signed [WIDTH_A-1:0] w_a1;
    logic signed [WIDTH_B-1:0] w_b1;
    logic                      w_v1;
    logic signed [WP-1:0]      w_a_ext;
    logic signed [WP-1:0]      w_b_ext;
    logic signed [WP-1:0]      w_prod;
    logic signed [WP-1:0]      w_m;
    logic                      w_v2;

    // Keeps the control inputs referenced when both stages are bypassed.
    logic w_unused_ctl;
    assign w_unused_ctl = ^{clk, rst_n, ce, rst_i, rst_m};

    if (IREG == 1) begin : g_ireg
        logic signed [WIDTH_A-1:0] r_a1;
        logic signed [WIDTH_B-1:0] r_b1;
        logic                      r_v1;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_a1 <= '0;
                r_b1 <= '0;
                r_v1 <= 1'b0;
            end else if (rst_i) begin
                r_a1 <= '0;
                r_b1 <= '0;
                r_v1 <= 1'b0;
            end else if (ce) begin
                r_a1 <= bus.a_in;
                r_b1 <= bus.b_in;
                r_v1 <= bus.in_valid;
            end
        end

        assign w_a1 = r_a1;
        assign w_b1 = r_b1;
        assign w_v1 = r_v1;
    end else begin : g_ibyp
        assign w_a1 = bus.a_in;
        assign w_b1 = bus.b_in;
        assign w_v1 = bus.in_valid;
    end

    // Sign-extend to the full product width so the low WP bits of the product are exact.
    assign w_a_ext = {{WIDTH_B{w_a1[WIDTH_A-1]}}, w_a1};
    assign w_b_ext = {{WIDTH_A{w_b1[WIDTH_B-1]}}, w_b1};
    assign w_prod  = w_a_ext * w_b_ext;

    if (MREG == 1) begin : g_mreg
        logic signed [WP-1:0] r_m;
        logic                 r_v2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_m  <= '0;
                r_v2 <= 1'b0;
            end else if (rst_m) begin
                r_m  <= '0;
                r_v2 <= 1'b0;
            end else if (ce) begin
                r_m  <= w_prod;
                r_v2 <= w_v1;
            end
        end

        assign w_m  = r_m;
        assign w_v2 = r_v2;
    end else begin : g_mbyp
        assign w_m  = w_prod;
        assign w_v2 = w_v1;
    end

    assign bus.m_out     = w_m;
    assign bus.bcout     = w_b1;
    assign bus.out_valid = w_v2;
endmodule

// File: tb/tb_dsp_mult_stage.sv
// Scoreboard bench for dsp_mult_stage: full pipeline (1/1) plus both bypass configurations.
module tb_dsp_mult_stage;
    localparam int WA = 18;
    localparam int WB = 18;
    localparam int WP = WA + WB;

    logic clk = 1'b0;
    logic rst_n;
    logic ce;
    logic rst_i;
    logic rst_m;
    logic                 tb_v;
    logic signed [WA-1:0] tb_a;
    logic signed [WB-1:0] tb_b;

    int n_tests = 0;
    int n_fail  = 0;
    logic signed [WP-1:0] sb[$];

    always #5 clk = ~clk;

    dsp_mult_stage_if #(.WIDTH_A(WA), .WIDTH_B(WB)) bus11 ();
    dsp_mult_stage_if #(.WIDTH_A(WA), .WIDTH_B(WB)) bus00 ();
    dsp_mult_stage_if #(.WIDTH_A(WA), .WIDTH_B(WB)) bus10 ();

    assign bus11.in_valid = tb_v;
    assign bus11.a_in     = tb_a;
    assign bus11.b_in     = tb_b;
    assign bus00.in_valid = tb_v;
    assign bus00.a_in     = tb_a;
    assign bus00.b_in     = tb_b;
    assign bus10.in_valid = tb_v;
    assign bus10.a_in     = tb_a;
    assign bus10.b_in     = tb_b;

    dsp_mult_stage #(.WIDTH_A(WA), .WIDTH_B(WB), .IREG(1), .MREG(1)) u_dut11 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .rst_i(rst_i), .rst_m(rst_m), .bus(bus11)
    );
    dsp_mult_stage #(.WIDTH_A(WA), .WIDTH_B(WB), .IREG(0), .MREG(0)) u_dut00 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .rst_i(rst_i), .rst_m(rst_m), .bus(bus00)
    );
    dsp_mult_stage #(.WIDTH_A(WA), .WIDTH_B(WB), .IREG(1), .MREG(0)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .rst_i(rst_i), .rst_m(rst_m), .bus(bus10)
    );

    task automatic chk(input string tag, input logic signed [WP-1:0] got, input logic signed [WP-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic signed [WP-1:0] mul(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return p[WP-1:0];
    endfunction

    // One clock of stimulus on the full pipeline; pushes accepted inputs, pops on new products.
    task automatic cycle(input logic v, input int a, input int b, input logic signed [WP-1:0] exp,
                         input logic c, input logic ri, input logic rm);
        tb_v  = v;
        tb_a  = a[WA-1:0];
        tb_b  = b[WB-1:0];
        ce    = c;
        rst_i = ri;
        rst_m = rm;
        @(posedge clk);
        if (c && v && !ri) sb.push_back(exp);
        #1;
        if (c && !rm && bus11.out_valid) begin
            if (sb.size() == 0) chk("no_stale_valid", {{(WP-1){1'b0}}, bus11.out_valid}, '0);
            else                chk("product", bus11.m_out, sb.pop_front());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ce = 1'b0; rst_i = 1'b0; rst_m = 1'b0;
        tb_v = 1'b0; tb_a = '0; tb_b = '0;
        #2;
        chk("rst_m_out", bus11.m_out, '0);
        chk("rst_bcout", bus11.bcout, '0);
        chk("rst_valid", bus11.out_valid, '0);
        #6 rst_n = 1'b1;

        // Basic: 3 * -5 with latency 2, bcout after 1 edge
        cycle(1'b1, 3, -5, 36'hFFFFFFFF1, 1'b1, 1'b0, 1'b0);
        chk("basic_bcout", bus11.bcout, -5);
        chk("basic_valid_e1", bus11.out_valid, 0);
        idle(1);
        chk("basic_valid_e2", bus11.out_valid, 1);
        chk("basic_m_e2", bus11.m_out, 36'hFFFFFFFF1);
        idle(1);
        chk("basic_valid_e3", bus11.out_valid, 0);

        // Extremes
        cycle(1'b1, -131072, -131072, 36'h400000000, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 131071, -131072, 36'hC00020000, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Back-to-back stream with a two-cycle stall after the second input
        cycle(1'b1, 1, 1, 36'd1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 2, 2, 36'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 3, 3, 36'd9, 1'b0, 1'b0, 1'b0);
            chk("stall_m_hold", bus11.m_out, 36'd1);
            chk("stall_v_hold", bus11.out_valid, 1);
        end
        cycle(1'b1, 3, 3, 36'd9, 1'b1, 1'b0, 1'b0);
        idle(1);
        idle(1);
        chk("stream_valid_end", bus11.out_valid, 0);

        // rst_m clears a valid product sitting in M
        cycle(1'b1, 5, 6, 36'd30, 1'b1, 1'b0, 1'b0);
        idle(1);
        cycle(1'b0, 0, 0, '0, 1'b1, 1'b0, 1'b1);
        chk("rstm_m", bus11.m_out, '0);
        chk("rstm_valid", bus11.out_valid, 0);

        // rst_i honoured with ce=0
        cycle(1'b0, 0, 9, '0, 1'b1, 1'b0, 1'b0);
        chk("bcout_load", bus11.bcout, 9);
        cycle(1'b0, 0, 11, '0, 1'b0, 1'b1, 1'b0);
        chk("rsti_ce0_bcout", bus11.bcout, 0);

        // rst_i alone: stage 2 still captures the pre-clear product
        cycle(1'b1, 5, 7, 36'd35, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8, 8, 36'd64, 1'b1, 1'b1, 1'b0);
        chk("rsti_bcout", bus11.bcout, 0);
        chk("rsti_m_kept", bus11.m_out, 36'd35);
        idle(1);
        chk("rsti_v_cleared", bus11.out_valid, 0);

        // rst_i and rst_m together flush both stages
        cycle(1'b1, 4, 4, 36'd16, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 2, 2, 36'd4, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 0, 0, '0, 1'b1, 1'b1, 1'b1);
        sb.delete();
        chk("both_m", bus11.m_out, '0);
        chk("both_bcout", bus11.bcout, '0);
        chk("both_valid", bus11.out_valid, 0);
        idle(2);

        // Asynchronous reset mid-stream, between edges
        cycle(1'b1, 3, 3, 36'd9, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 4, 4, 36'd16, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_m", bus11.m_out, '0);
        chk("arst_bcout", bus11.bcout, '0);
        chk("arst_valid", bus11.out_valid, 0);
        sb.delete();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("arst_no_stale", bus11.out_valid, 0);
        end

        // Bypass configurations
        tb_v = 1'b1; tb_a = 18'sd7; tb_b = 18'sd6; ce = 1'b1;
        #1;
        chk("byp00_m", bus00.m_out, 36'd42);
        chk("byp00_valid", bus00.out_valid, 1);
        chk("byp00_bcout", bus00.bcout, 6);
        chk("byp10_pre_valid", bus10.out_valid, 0);
        cycle(1'b1, 7, 6, 36'd42, 1'b1, 1'b0, 1'b0);
        chk("byp10_m", bus10.m_out, 36'd42);
        chk("byp10_valid", bus10.out_valid, 1);
        tb_v = 1'b0;
        #1;
        chk("byp00_valid_drop", bus00.out_valid, 0);
        idle(1);
        chk("byp10_valid_drop", bus10.out_valid, 0);
        idle(2);

        // Random stream with random stalls
        for (int i = 0; i < 60; i++) begin
            int ra;
            int rb;
            logic rv;
            logic rc;
            ra = int'($urandom_range(0, 262143)) - 131072;
            rb = int'($urandom_range(0, 262143)) - 131072;
            rv = 1'($urandom_range(0, 3) != 0);
            rc = 1'($urandom_range(0, 4) != 0);
            cycle(rv, ra, rb, mul(ra, rb), rc, 1'b0, 1'b0);
        end
        idle(3);
        chk("sb_drained", WP'(sb.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dsp_mult_stage.md
# dsp_mult_stage

Pipelined signed multiplier stage of the DSP48A1 datapath. It sits directly downstream of the pre-adder/subtractor mux. It captures the pre-adder result as the B operand and the A port as the second operand into optional A1/B1 input registers, then forms the 36-bit two's-complement product into an optional M register. A valid tag travels alongside the data, so the post-adder stage knows when a product is meaningful.

## Interface
Parameters:
- WIDTH_A, default 18: width of the A operand, signed.
- WIDTH_B, default 18: width of the B operand (pre-adder output), signed.
- IREG, default 1: 1 registers both A1 and B1; 0 bypasses both.
- MREG, default 1: 1 registers the product; 0 makes M combinational.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset; clears every register and valid bit.
- ce  in  1  global clock enable; 1 advances all pipeline registers, 0 holds all state.
- rst_i  in  1  synchronous active-high clear of the A1/B1 registers and stage-1 valid.
- rst_m  in  1  synchronous active-high clear of the M register and stage-2 valid.
- in_valid  in  1  qualifies a_in/b_in this cycle.
- a_in  in  WIDTH_A  A operand, signed.
- b_in  in  WIDTH_B  B operand from the pre-adder/subtractor mux, signed.
- m_out  out  WIDTH_A+WIDTH_B  signed product.
- bcout  out  WIDTH_B  B1 register output (b_in directly when IREG=0); cascade to the next slice.
- out_valid  out  1  m_out holds a product derived from a valid input.

## Operation
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Stage 1 (IREG=1):
  - On a clk edge with ce=1: a1 <= a_in, b1 <= b_in, v1 <= in_valid.
  - If rst_i=1 on that edge, a1, b1 and v1 go to 0.
  - rst_i has priority over ce and is honoured even when ce=0.
- Stage 2 (MREG=1):
  - On a clk edge with ce=1: m <= signed(a1) * signed(b1), v2 <= v1.
  - If rst_m=1 on that edge, m and v2 go to 0; rst_m has priority over ce.
- Bypassed stages:
  - A bypassed stage passes its inputs combinationally, including the valid bit.
  - Its synchronous reset input has no effect.
- Arithmetic: full-precision signed multiply; result is WIDTH_A+WIDTH_B bits with no truncation or saturation.
- ce=0: all registers and valid bits hold. out_valid may remain 1 across a stall; the downstream stage must qualify on its own enable.
- rst_n=0 (asynchronous, any time): a1, b1, m, v1, v2 go to 0 immediately. Operation resumes on the first clk edge after deassertion.

## Timing
- Latency from in_valid/a_in/b_in to m_out/out_valid is L = IREG + MREG rising edges with ce=1. L is 0, 1 or 2.
- bcout latency is IREG edges.
- Throughput: one product per ce=1 cycle; no bubbles are inserted.
- Reset values: m_out=0, bcout=0, out_valid=0.
- Simultaneous events:
  - rst_i and rst_m together clear both stages on the same edge.
  - rst_i alone clears stage 1, while stage 2 still captures the pre-clear a1*b1 (ce=1) and v1.
- Reset mid-operation: any in-flight product is discarded and is never presented with out_valid=1.

## Test plan
- Basic (IREG=1, MREG=1):
  - Stimulus: a_in=3, b_in=-5, in_valid=1 for one cycle, ce=1.
  - Response: out_valid=1 exactly 2 edges later with m_out=36'hFFFFFFFF1 (-15); bcout=-5 after 1 edge.
- Extremes:
  - Stimulus: a_in=-131072, b_in=-131072.
  - Response: m_out=36'h400000000.
  - Stimulus: a_in=131071, b_in=-131072.
  - Response: m_out=36'hC00020000.
- Back-to-back stream with stall:
  - Stimulus: products 1*1, 2*2, 3*3 on consecutive cycles, with ce=0 for 2 cycles after the second input.
  - Response: outputs 1, 4, 9 in order; m_out and out_valid hold during the stall.
- Sync clears:
  - Stimulus: rst_m=1 while a valid product sits in M.
  - Response: m_out=0 and out_valid=0 next edge.
  - Stimulus: rst_i=1 with ce=0.
  - Response: bcout=0 next edge anyway.
- Async reset:
  - Stimulus: rst_n pulsed low mid-stream, between clock edges.
  - Response: outputs read 0 before the next edge; no stale valid appears after release.
- Bypass (IREG=0, MREG=0):
  - Stimulus: a_in=7, b_in=6.
  - Response: m_out=42 and out_valid follows in_valid combinationally.
  - Repeat with IREG=1, MREG=0 and confirm latency is 1.
